bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   It is the inverse path of the BCD adder: it turns a binary count or
//   switch value into BCD digits plus active-low 7-segment patterns for the
//   HEX displays.
//   A start/busy/done handshake lets a controller FSM or counter drive it.
// PARAMETERS
//   WIDTH   7  binary input width, in bits
//   DIGITS  2  BCD output digits; in-range max is 10^DIGITS-1 (99 by default)
// PORTS
//   clk    in   1           system clock; all logic on the rising edge
//   rst_n  in   1           asynchronous reset, active-low
//   start  in   1           conversion request; sampled only while accepting
//   bin    in   WIDTH       binary operand; latched on the accepted start
//   busy   out  1           high while a conversion is in progress
//   done   out  1           one-cycle pulse when the result registers update
//   err    out  1           latched operand exceeded 10^DIGITS-1
//   bcd    out  4*DIGITS    result; digit 0 (units) is bcd[3:0]
//   hex    out  7*DIGITS    segments per digit; digit k is hex[7k+6:7k]
//                           bit order within a digit is a..g, from MSB to LSB
// BEHAVIOUR
//   One clock (clk). Reset is asynchronous and active-low (rst_n).
//   Reset (rst_n=0, applied asynchronously):
//     state=IDLE, busy=0, done=0, err=0, bcd=0, all hex digits=7'b1111111.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE : start=1 -> latch bin, compute ovf, clear scratch, set cnt=0,
//            go to SHIFT.
//     SHIFT: each cycle, add 3 to every scratch digit >=5, then shift
//            {scratch,bin_reg} left by 1 and increment cnt.
//            When cnt==WIDTH-1, go to DONE.
//     DONE : register the outputs, done=1 for exactly this cycle.
//            start=1 here is accepted, as in IDLE (back-to-back conversions).
//            Otherwise go to IDLE.
//   Handshake and latency:
//     - busy=1 in SHIFT only.
//     - start is ignored while busy=1. A held start re-triggers only in
//       IDLE or DONE.
//     - Start accepted at edge N -> done=1 in cycle N+WIDTH+1.
//       Latency is fixed and independent of the operand value.
//     - bin may change freely after the accepting edge.
//   Width rules:
//     - The scratch register holds at least ceil(WIDTH*0.302)+1 digits, so
//       the add-3 step never loses a carry.
//     - bcd takes the low DIGITS digits of the scratch register.
//   Overflow:
//     - ovf = (bin > 10^DIGITS-1), evaluated on the latched value.
//     - The conversion still runs, so latency stays constant.
//     - At DONE with ovf=1: err=1, bcd=0, all hex digits=7'b1111111 (blank).
//     - At DONE with ovf=0: err=0 and normal outputs.
//   Output timing:
//     - bcd, hex and err change only in the DONE cycle.
//     - They hold the previous result throughout SHIFT.
//   Segment table per digit (active-low, a..g):
//     0=0000001  1=1001111  2=0010010  3=0000110  4=1001100
//     5=0100100  6=0100000  7=0001111  8=0000000  9=0000100
//     any other code=1111111
//   Leading digits are NOT blanked; 5 is displayed as "05".
//   Reset asserted mid-SHIFT: conversion aborts, the reset values above apply
//   immediately, and no done pulse is produced.
// TESTING
//   1. Reset, then start with bin=0:
//      done at +8 cycles, bcd=8'h00, hex={0000001,0000001}, err=0.
//   2. bin=57: bcd=8'h57, hex1=0100100, hex0=0001111, err=0.
//   3. bin=99: bcd=8'h99, both digits=0000100. Then bin=100:
//      err=1, bcd=0, hex all ones, latency unchanged.
//   4. Start bin=42; pulse start with bin=13 while busy=1 (at +3):
//      the second start is ignored; result is bcd=8'h42 and only one done.
//   5. Hold start=1 with bin=7 then bin=88 presented at DONE:
//      done pulses 8 cycles apart, with results 8'h07 then 8'h88.
//   6. Assert rst_n=0 at cycle +4 of a conversion of bin=64:
//      busy=0, bcd=0, hex blank, no done. A fresh start then gives 8'h64.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/busy/done
// handshake, overflow flag and active-low 7-segment patterns per digit.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  // Scratch must hold enough digits that add-3 never drops a carry.
  localparam int SDIG_MIN = (WIDTH * 302 + 999) / 1000 + 1;
  localparam int SDIG     = (SDIG_MIN > DIGITS) ? SDIG_MIN : DIGITS;
  localparam int SW       = 4 * SDIG;
  localparam int CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [31:0] max_value(input int d);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < d; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  localparam logic [31:0] MAXV = max_value(DIGITS);

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic                   last;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf;
  logic [SW-1:0]          scr, scr_adj, scr_nxt;
  logic [WIDTH-1:0]       sh, sh_nxt;
  logic [7*DIGITS-1:0]    hex_nxt;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last = (state == SHIFT) && (cnt == CNT_LAST);
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        ovf <= (32'(bin) > MAXV);
      end else if (state == SHIFT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Shift datapath: add-3 on every digit, then shift {scratch, operand} left.
  always_comb begin
    scr_adj = scr;
    for (int d = 0; d < SDIG; d++) scr_adj[4*d +: 4] = add3(scr[4*d +: 4]);
    {scr_nxt, sh_nxt} = {scr_adj, sh} << 1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sh  <= bin;
      scr <= '0;
    end else if (state == SHIFT) begin
      sh  <= sh_nxt;
      scr <= scr_nxt;
    end
  end

  always_comb begin
    hex_nxt = '1;
    for (int d = 0; d < DIGITS; d++) hex_nxt[7*d +: 7] = seg7(scr_nxt[4*d +: 4]);
  end

  // Results are taken from the final shift so they appear in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
      bcd <= '0;
      hex <= '1;
    end else if (last) begin
      err <= ovf;
      if (ovf) begin
        bcd <= '0;
        hex <= '1;
      end else begin
        bcd <= scr_nxt[4*DIGITS-1:0];
        hex <= hex_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, results, overflow, handshake,
// back-to-back starts and reset during a conversion.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  bin;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  bcd;
  logic [13:0] hex;

  int errors;
  int checks;

  bin_to_bcd_seq #(.WIDTH(7), .DIGITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bcd   (bcd),
    .hex   (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [13:0] BLANK = 14'h3fff;

  // Drive start for one accepting edge, then report latency in cycles counted
  // from the start cycle (done expected in cycle 8) and the done pulse count.
  task automatic run_conv(input logic [6:0] v, output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = ~v;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (lat < 0) lat = k + 1;
      end
    end
  endtask

  task automatic check_result(input string name, input logic [7:0] e_bcd,
                              input logic [13:0] e_hex, input logic e_err,
                              input int lat, input int pulses);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 8", name, lat);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL %s done pulses: got %0d expected 1", name, pulses);
    end
    checks++;
    if (bcd !== e_bcd) begin
      errors++;
      $display("FAIL %s bcd: got %h expected %h", name, bcd, e_bcd);
    end
    checks++;
    if (hex !== e_hex) begin
      errors++;
      $display("FAIL %s hex: got %b expected %b", name, hex, e_hex);
    end
    checks++;
    if (err !== e_err) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", name, err, e_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset flags: got busy/done/err=%b expected 000", {busy, done, err});
    end
    checks++;
    if (bcd !== 8'h00 || hex !== BLANK) begin
      errors++;
      $display("FAIL reset outputs: got bcd=%h hex=%b expected 00 / all ones", bcd, hex);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_values();
    int lat, pulses;
    run_conv(7'd0, lat, pulses);
    check_result("bin0", 8'h00, 14'b0000001_0000001, 1'b0, lat, pulses);
    run_conv(7'd57, lat, pulses);
    check_result("bin57", 8'h57, 14'b0100100_0001111, 1'b0, lat, pulses);
    run_conv(7'd99, lat, pulses);
    check_result("bin99", 8'h99, 14'b0000100_0000100, 1'b0, lat, pulses);
    run_conv(7'd5, lat, pulses);
    check_result("bin5", 8'h05, 14'b0000001_0100100, 1'b0, lat, pulses);
  endtask

  task automatic test_overflow();
    int lat, pulses;
    run_conv(7'd100, lat, pulses);
    check_result("bin100", 8'h00, BLANK, 1'b1, lat, pulses);
    run_conv(7'd127, lat, pulses);
    check_result("bin127", 8'h00, BLANK, 1'b1, lat, pulses);
    run_conv(7'd42, lat, pulses);
    check_result("after_ovf42", 8'h42, 14'b1001100_0010010, 1'b0, lat, pulses);
  endtask

  task automatic test_busy_ignore();
    int lat, pulses;
    logic [7:0] held;
    lat    = -1;
    pulses = 0;
    held   = bcd;
    @(negedge clk);
    start = 1'b1;
    bin   = 7'd42;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b1;
        bin   = 7'd13;
      end else if (k == 2) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bcd !== held) begin
          errors++;
          $display("FAIL busy_hold: got busy=%b bcd=%h expected 1 / %h", busy, bcd, held);
        end
      end
      if (done) begin
        pulses++;
        if (lat < 0) lat = k + 1;
      end
    end
    check_result("busy_ignore", 8'h42, 14'b1001100_0010010, 1'b0, lat, pulses);
  endtask

  task automatic test_back_to_back();
    int first, second, n;
    first  = -1;
    second = -1;
    n      = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 7'd7;
    @(posedge clk);
    #1;
    bin = 7'd3;
    for (int k = 0; k < 30 && second < 0; k++) begin
      @(negedge clk);
      if (done) begin
        n++;
        if (first < 0) begin
          first = k;
          checks++;
          if (bcd !== 8'h07 || hex !== 14'b0000001_0001111) begin
            errors++;
            $display("FAIL b2b_first: got bcd=%h hex=%b expected 07 / 0000001_0001111", bcd, hex);
          end
          bin = 7'd88;
        end else begin
          second = k;
          start  = 1'b0;
          checks++;
          if (bcd !== 8'h88 || hex !== 14'b0000000_0000000) begin
            errors++;
            $display("FAIL b2b_second: got bcd=%h hex=%b expected 88 / all zeros", bcd, hex);
          end
        end
      end else if (first >= 0) begin
        bin = 7'd1;
      end
    end
    start = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) !== 8) begin
      errors++;
      $display("FAIL b2b_spacing: got first=%0d second=%0d expected spacing 8", first, second);
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d expected 2", n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 7'd64;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 8'h00 || hex !== BLANK) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b bcd=%h hex=%b expected 0/0/00/blank",
               busy, done, bcd, hex);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_nodone: got %0d pulses expected 0", pulses);
    end
    run_conv(7'd64, lat, pulses);
    check_result("after_reset64", 8'h64, 14'b0100000_1001100, 1'b0, lat, pulses);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_values();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
